multi_ctrl_ext: RTL and testbench
=================================

Name: multi_ctrl_ext

Overview:
Next-generation multi-cycle MIPS control unit. It drives the shared-memory multi-cycle datapath (PC, IR, MDR, A/B, ALUOut registers) and adds support for:
- I-type ALU ops, bne, jal and jr;
- memory wait states on every memory access via MIO_ready;
- a signed-overflow trap and a sticky error state.

It sits between the instruction register and the datapath mux/write-enable controls, in place of the previous controller.

Parameters:
MEM_WAIT, 1, 1 = data-memory states (MEM_RD, MEM_W) hold until MIO_ready; 0 = single-cycle data access.
OVF_TRAP, 1, 1 = add/sub/addi overflow suppresses write-back and enters ERROR; 0 = overflow ignored.
STATE_W, 5, width of state_out (must be ≥5).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
Inst_in  in  32  IR contents; opcode [31:26], funct [5:0]
zero  in  1  ALU zero flag
overflow  in  1  ALU signed-overflow flag
MIO_ready  in  1  memory/IO access complete
state_out  out  STATE_W  current state, zero-extended
ALU_operation  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor, 011 xor, 101 srl
MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA  out  1  datapath controls
PCWrite, PCWriteCond, Branch, ZeroExt  out  1  PC/branch controls; ZeroExt=1 zero-extends imm16
RegDst  out  2  00 rt, 01 rd, 10 r31
MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC
ALUSrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 A (rs)
error  out  1  sticky; set on entry to ERROR

Behaviour:
- State register updates on posedge clk. Async reset forces IF, clears the ovf latch and clears error. All outputs are combinational from state (plus the gating listed below).
- Default: all controls 0 unless listed for a state.
- Encodings: IF=0, ID=1, MEM_EX=2, MEM_RD=3, LW_WB=4, MEM_W=5, R_EXC=6, R_WB=7, BEQ=8, J=9, I_EXC=10, I_WB=11, JAL=12, JR=13, BNE=14, ERROR=31.
- IF:
  - Controls: MemRead=1, CPU_MIO=1, ALUSrcB=01, ALU add.
  - IRWrite = PCWrite = MIO_ready.
  - Stay in IF until MIO_ready, then go to ID. Guarantees exactly one PC increment per fetch.
- ID:
  - Controls: ALUSrcB=11, ALU add (branch target into ALUOut).
  - Opcode 000000 with funct 001000 (jr) → JR; other funct → R_EXC.
  - 100011/101011 → MEM_EX; 000100 → BEQ; 000101 → BNE; 000010 → J; 000011 → JAL.
  - 001000/001100/001101/001110/001010 (addi/andi/ori/xori/slti) → I_EXC.
  - Anything else → ERROR.
- MEM_EX:
  - Controls: ALUSrcA=1, ALUSrcB=10, add.
  - lw → MEM_RD; sw → MEM_W.
- MEM_RD:
  - Controls: MemRead=1, IorD=1, CPU_MIO=1.
  - With MEM_WAIT=1, hold until MIO_ready; then → LW_WB.
- LW_WB: RegWrite=1, MemtoReg=01, RegDst=00; → IF.
- MEM_W:
  - Controls: MemWrite=1, IorD=1, CPU_MIO=1.
  - Wait as for MEM_RD; → IF.
- R_EXC:
  - Controls: ALUSrcA=1, ALUSrcB=00.
  - Funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 000010 srl.
  - Unknown funct → add.
  - Latch ovf = overflow & (funct is add or sub); → R_WB.
- R_WB:
  - Controls: RegDst=01, MemtoReg=00.
  - RegWrite = ~(ovf & OVF_TRAP).
  - → ERROR if ovf & OVF_TRAP, else → IF.
- I_EXC:
  - Controls: ALUSrcA=1, ALUSrcB=10.
  - ALU op per opcode: addi add, andi and, ori or, xori xor, slti slt.
  - ZeroExt=1 for andi/ori/xori.
  - ovf latched for addi only; → I_WB.
- I_WB: as R_WB but RegDst=00.
- BEQ:
  - Controls: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01, PCWriteCond=1, Branch=1.
  - PCWrite = zero; → IF.
- BNE: as BEQ but Branch=0 and PCWrite = ~zero; → IF.
- J: PCWrite=1, PCSource=10; → IF.
- JAL:
  - Controls: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10.
  - PC already holds PC+4 when written to r31; → IF.
- JR: PCWrite=1, PCSource=11; → IF.
- ERROR:
  - All controls 0, error=1. Stays in ERROR until reset.
  - Any unreachable state value → ERROR.
- Reset asserted mid-access (MEM_RD/MEM_W/IF wait): controls drop to IF values immediately; no write-enable survives past reset assertion.

Test Plan:
- Reset, then fetch with MIO_ready low 3 cycles then high → state_out=0 for 4 cycles; PCWrite/IRWrite high only in the 4th; next state 1.
- lw with MIO_ready low 2 cycles in MEM_RD → states 0,1,2,3,3,3,4,0; RegWrite=1, MemtoReg=01 only in state 4.
- add (funct 100000) with overflow=1 in R_EXC, OVF_TRAP=1 → R_WB has RegWrite=0; then state 31, error=1 held across 10 cycles until reset.
- bne with zero=1 → PCWrite=0, PCWriteCond=1, Branch=0; repeat with zero=0 → PCWrite=1, PCSource=01.
- jal 0x0C000010 → JAL state 12: RegDst=10, MemtoReg=10, RegWrite=1, PCSource=10. jr (funct 001000) → state 13, PCSource=11.
- ori (opcode 001101) → I_EXC with ALU_operation=001, ZeroExt=1. Undefined opcode 111111 → state 31.

Source files
------------

// File: rtl/multi_ctrl_ext.sv
// -----------------------------------------------------------------------------
// multi_ctrl_ext
//
// Multi-cycle MIPS control unit for the shared-memory datapath (PC, IR, MDR,
// A/B, ALUOut). It supports R-type ALU ops, jr, lw/sw, beq/bne, j/jal and the
// I-type ALU ops addi/andi/ori/xori/slti. Every fetch and, when MEM_WAIT=1,
// every data access stalls until MIO_ready. A signed overflow on add/sub/addi
// can trap into a sticky ERROR state when OVF_TRAP=1.
//
// Parameters
//   MEM_WAIT  1: MEM_RD / MEM_W hold until MIO_ready; 0: single-cycle access
//   OVF_TRAP  1: add/sub/addi overflow suppresses write-back and enters ERROR
//   STATE_W   width of state_out (>= 5)
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   Inst_in[31:0]     IR contents (opcode [31:26], funct [5:0])
//   zero, overflow    ALU flags
//   MIO_ready         memory/IO access complete
//   state_out         current state, zero-extended to STATE_W bits
//   ALU_operation     000 and, 001 or, 010 add, 110 sub, 111 slt,
//                     100 nor, 011 xor, 101 srl
//   MemRead .. ALUSrcA        datapath enables / selects
//   PCWrite, PCWriteCond, Branch, ZeroExt   PC and immediate controls
//   RegDst, MemtoReg, ALUSrcB, PCSource     2-bit mux selects
//   error             high while the controller sits in ERROR
// -----------------------------------------------------------------------------
module multi_ctrl_ext #(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit OVF_TRAP = 1'b1,
  parameter int STATE_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Inst_in,
  input  logic               zero,
  input  logic               overflow,
  input  logic               MIO_ready,
  output logic [STATE_W-1:0] state_out,
  output logic [2:0]         ALU_operation,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               CPU_MIO,
  output logic               IorD,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Branch,
  output logic               ZeroExt,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               error
);

  typedef enum logic [4:0] {
    S_IF     = 5'd0,
    S_ID     = 5'd1,
    S_MEM_EX = 5'd2,
    S_MEM_RD = 5'd3,
    S_LW_WB  = 5'd4,
    S_MEM_W  = 5'd5,
    S_R_EXC  = 5'd6,
    S_R_WB   = 5'd7,
    S_BEQ    = 5'd8,
    S_J      = 5'd9,
    S_I_EXC  = 5'd10,
    S_I_WB   = 5'd11,
    S_JAL    = 5'd12,
    S_JR     = 5'd13,
    S_BNE    = 5'd14,
    S_ERROR  = 5'd31
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state;
  logic       ovf;      // overflow seen in the execute cycle of this instruction
  logic       trap;     // write-back must be suppressed and ERROR entered
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_inst;

  assign opcode      = Inst_in[31:26];
  assign funct       = Inst_in[5:0];
  assign unused_inst = ^Inst_in[25:6];
  assign trap        = ovf & OVF_TRAP;

  // ---------------------------------------------------------------------------
  // State register and overflow latch
  // ---------------------------------------------------------------------------
  // NOTE: state is only ever updated with non-blocking assignments so every
  // flop samples the pre-edge values; the reset branch is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IF;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IF: begin
          // The fetch is retired exactly once, in the cycle MIO_ready rises.
          if (MIO_ready) state <= S_ID;
        end

        S_ID: begin
          case (opcode)
            OP_RTYPE: state <= (funct == FN_JR) ? S_JR : S_R_EXC;
            OP_LW,
            OP_SW:    state <= S_MEM_EX;
            OP_BEQ:   state <= S_BEQ;
            OP_BNE:   state <= S_BNE;
            OP_J:     state <= S_J;
            OP_JAL:   state <= S_JAL;
            OP_ADDI,
            OP_ANDI,
            OP_ORI,
            OP_XORI,
            OP_SLTI:  state <= S_I_EXC;
            default:  state <= S_ERROR;
          endcase
        end

        S_MEM_EX: begin
          if (opcode == OP_LW)      state <= S_MEM_RD;
          else if (opcode == OP_SW) state <= S_MEM_W;
          else                      state <= S_ERROR;
        end

        S_MEM_RD: begin
          if (!MEM_WAIT || MIO_ready) state <= S_LW_WB;
        end

        S_MEM_W: begin
          if (!MEM_WAIT || MIO_ready) state <= S_IF;
        end

        S_R_EXC: begin
          ovf   <= overflow & ((funct == FN_ADD) || (funct == FN_SUB));
          state <= S_R_WB;
        end

        S_I_EXC: begin
          ovf   <= overflow & (opcode == OP_ADDI);
          state <= S_I_WB;
        end

        S_R_WB,
        S_I_WB: state <= trap ? S_ERROR : S_IF;

        S_LW_WB,
        S_BEQ,
        S_BNE,
        S_J,
        S_JAL,
        S_JR:    state <= S_IF;

        // ERROR is absorbing; any encoding outside the table also lands here.
        default: state <= S_ERROR;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control decode: purely a function of state, plus MIO_ready / zero / ovf
  // gating on the enables that depend on them.
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so that no state leaves
  // a control unassigned and no latch is inferred.
  always_comb begin
    ALU_operation = ALU_AND;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    CPU_MIO       = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    ZeroExt       = 1'b0;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    error         = 1'b0;

    case (state)
      S_IF: begin
        MemRead       = 1'b1;
        CPU_MIO       = 1'b1;
        ALUSrcB       = 2'b01;
        ALU_operation = ALU_ADD;
        IRWrite       = MIO_ready;
        PCWrite       = MIO_ready;
      end

      S_ID: begin
        // Precompute the branch target into ALUOut.
        ALUSrcB       = 2'b11;
        ALU_operation = ALU_ADD;
      end

      S_MEM_EX: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_operation = ALU_ADD;
      end

      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        CPU_MIO = 1'b1;
      end

      S_LW_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end

      S_MEM_W: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        CPU_MIO  = 1'b1;
      end

      S_R_EXC: begin
        ALUSrcA = 1'b1;
        case (funct)
          FN_SUB:  ALU_operation = ALU_SUB;
          FN_AND:  ALU_operation = ALU_AND;
          FN_OR:   ALU_operation = ALU_OR;
          FN_XOR:  ALU_operation = ALU_XOR;
          FN_NOR:  ALU_operation = ALU_NOR;
          FN_SLT:  ALU_operation = ALU_SLT;
          FN_SRL:  ALU_operation = ALU_SRL;
          default: ALU_operation = ALU_ADD;  // add and unknown functs
        endcase
      end

      S_R_WB: begin
        RegDst   = 2'b01;
        RegWrite = ~trap;
      end

      S_I_EXC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (opcode)
          OP_ANDI: begin ALU_operation = ALU_AND; ZeroExt = 1'b1; end
          OP_ORI:  begin ALU_operation = ALU_OR;  ZeroExt = 1'b1; end
          OP_XORI: begin ALU_operation = ALU_XOR; ZeroExt = 1'b1; end
          OP_SLTI: ALU_operation = ALU_SLT;
          default: ALU_operation = ALU_ADD;
        endcase
      end

      S_I_WB: begin
        RegWrite = ~trap;
      end

      S_BEQ: begin
        ALUSrcA       = 1'b1;
        ALU_operation = ALU_SUB;
        PCSource      = 2'b01;
        PCWriteCond   = 1'b1;
        Branch        = 1'b1;
        PCWrite       = zero;
      end

      S_BNE: begin
        ALUSrcA       = 1'b1;
        ALU_operation = ALU_SUB;
        PCSource      = 2'b01;
        PCWriteCond   = 1'b1;
        PCWrite       = ~zero;
      end

      S_J: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end

      S_JAL: begin
        // PC already holds PC+4, which is what lands in r31.
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
      end

      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end

      S_ERROR: error = 1'b1;

      default: ;
    endcase
  end

  assign state_out = STATE_W'(state);

endmodule

// File: tb/tb_multi_ctrl_ext.sv
// -----------------------------------------------------------------------------
// tb_multi_ctrl_ext
//
// Scoreboard bench for multi_ctrl_ext. A reference model expands each
// instruction (by instruction class, wait counts and ALU flags) into the list
// of cycles it should take and the full control vector of every cycle. The
// stimulus process drives inputs and pushes the expected vector; an independent
// monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_multi_ctrl_ext;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Inst_in = '0;
  logic        zero = 1'b0;
  logic        overflow = 1'b0;
  logic        MIO_ready = 1'b0;
  logic [4:0]  state_out;
  logic [2:0]  ALU_operation;
  logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA;
  logic        PCWrite, PCWriteCond, Branch, ZeroExt;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic        error;

  multi_ctrl_ext #(.MEM_WAIT(1'b1), .OVF_TRAP(1'b1), .STATE_W(5)) dut (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero),
    .overflow(overflow), .MIO_ready(MIO_ready), .state_out(state_out),
    .ALU_operation(ALU_operation), .MemRead(MemRead), .MemWrite(MemWrite),
    .CPU_MIO(CPU_MIO), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Branch(Branch), .ZeroExt(ZeroExt), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] st;
    logic [2:0] alu;
    logic       mem_read, mem_write, cpu_mio, iord, ir_write, reg_write;
    logic       alu_src_a, pc_write, pc_write_cond, branch, zero_ext;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic       err;
  } ctl_t;

  typedef struct {
    ctl_t  c;
    logic  rdy, z, o;
    string tag;
  } step_t;

  typedef struct {
    ctl_t  c;
    string tag;
  } exp_t;

  typedef enum {K_R, K_JR, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_I, K_BAD} kind_t;

  step_t plan[$];
  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    plan_errs;  // the current plan ends in the ERROR state

  ctl_t act;
  always_comb begin
    act = '{st: state_out, alu: ALU_operation, mem_read: MemRead,
            mem_write: MemWrite, cpu_mio: CPU_MIO, iord: IorD,
            ir_write: IRWrite, reg_write: RegWrite, alu_src_a: ALUSrcA,
            pc_write: PCWrite, pc_write_cond: PCWriteCond, branch: Branch,
            zero_ext: ZeroExt, reg_dst: RegDst, mem_to_reg: MemtoReg,
            alu_src_b: ALUSrcB, pc_source: PCSource, err: error};
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e.c) begin
          errors++;
          $display("FAIL %s: got st=%0d alu=%b vec=%h, expected st=%0d alu=%b vec=%h",
                   e.tag, act.st, act.alu, act, e.c.st, e.c.alu, e.c);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ctl_t blank(input logic [4:0] s);
    ctl_t c;
    c = '0;
    c.st = s;
    return c;
  endfunction

  function automatic kind_t classify(input logic [31:0] i);
    case (i[31:26])
      6'h00: return (i[5:0] == 6'h08) ? K_JR : K_R;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e: return K_I;
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h26: return 3'b011;
      6'h27: return 3'b100;
      6'h2a: return 3'b111;
      6'h02: return 3'b101;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(input logic [5:0] op);
    case (op)
      6'h0c: return 3'b000;
      6'h0d: return 3'b001;
      6'h0e: return 3'b011;
      6'h0a: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic ctl_t fetch_ctl(input logic rdy);
    ctl_t c;
    c = blank(5'd0);
    c.mem_read = 1'b1; c.cpu_mio = 1'b1; c.alu_src_b = 2'b01; c.alu = 3'b010;
    c.ir_write = rdy;  c.pc_write = rdy;
    return c;
  endfunction

  task automatic add(input ctl_t c, input logic rdy, z, o, input string tag);
    step_t s;
    s.c = c; s.rdy = rdy; s.z = z; s.o = o;
    s.tag = $sformatf("%s/st%0d", tag, c.st);
    plan.push_back(s);
  endtask

  task automatic add_error_tail(input string tag);
    ctl_t c;
    c = blank(5'd31);
    c.err = 1'b1;
    for (int k = 0; k < 10; k++) add(c, rb(), rb(), rb(), tag);
    plan_errs = 1'b1;
  endtask

  // Expand one instruction into its cycle-by-cycle expected behaviour.
  task automatic build(input logic [31:0] inst, input int fw, input int mw,
                       input logic z, input logic o, input string tag);
    ctl_t  c;
    kind_t k;
    bit    tr;
    plan.delete();
    plan_errs = 1'b0;
    k = classify(inst);
    for (int i = 0; i <= fw; i++) add(fetch_ctl(i == fw), (i == fw), rb(), rb(), tag);
    c = blank(5'd1); c.alu_src_b = 2'b11; c.alu = 3'b010;
    add(c, rb(), rb(), rb(), tag);
    case (k)
      K_LW, K_SW: begin
        c = blank(5'd2); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu = 3'b010;
        add(c, rb(), rb(), rb(), tag);
        for (int i = 0; i <= mw; i++) begin
          c = blank((k == K_LW) ? 5'd3 : 5'd5);
          c.iord = 1'b1; c.cpu_mio = 1'b1;
          if (k == K_LW) c.mem_read = 1'b1; else c.mem_write = 1'b1;
          add(c, (i == mw), rb(), rb(), tag);
        end
        if (k == K_LW) begin
          c = blank(5'd4); c.reg_write = 1'b1; c.mem_to_reg = 2'b01;
          add(c, rb(), rb(), rb(), tag);
        end
      end
      K_R, K_I: begin
        c = blank((k == K_R) ? 5'd6 : 5'd10);
        c.alu_src_a = 1'b1;
        if (k == K_R) begin
          c.alu = r_alu(inst[5:0]);
          tr = o && (inst[5:0] == 6'h20 || inst[5:0] == 6'h22);
        end else begin
          c.alu = i_alu(inst[31:26]);
          c.alu_src_b = 2'b10;
          c.zero_ext = (inst[31:26] inside {6'h0c, 6'h0d, 6'h0e});
          tr = o && (inst[31:26] == 6'h08);
        end
        add(c, rb(), rb(), o, tag);
        c = blank((k == K_R) ? 5'd7 : 5'd11);
        if (k == K_R) c.reg_dst = 2'b01;
        c.reg_write = !tr;
        add(c, rb(), rb(), rb(), tag);
        if (tr) add_error_tail(tag);
      end
      K_BEQ, K_BNE: begin
        c = blank((k == K_BEQ) ? 5'd8 : 5'd14);
        c.alu_src_a = 1'b1; c.alu = 3'b110; c.pc_source = 2'b01;
        c.pc_write_cond = 1'b1;
        c.branch = (k == K_BEQ);
        c.pc_write = (k == K_BEQ) ? z : !z;
        add(c, rb(), z, rb(), tag);
      end
      K_J, K_JAL, K_JR: begin
        c = blank((k == K_J) ? 5'd9 : (k == K_JAL) ? 5'd12 : 5'd13);
        c.pc_write = 1'b1;
        c.pc_source = (k == K_JR) ? 2'b11 : 2'b10;
        if (k == K_JAL) begin
          c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
        end
        add(c, rb(), rb(), rb(), tag);
      end
      default: add_error_tail(tag);
    endcase
  endtask

  // ---------------- stimulus ----------------
  // Called at posedge+1; each step occupies exactly one clock period.
  task automatic run_plan(input int n);
    int lim;
    lim = (n < 0 || n > plan.size()) ? plan.size() : n;
    for (int i = 0; i < lim; i++) begin
      exp_t e;
      MIO_ready = plan[i].rdy;
      zero      = plan[i].z;
      overflow  = plan[i].o;
      e.c = plan[i].c;
      e.tag = plan[i].tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    reset     = 1'b1;
    MIO_ready = 1'b0;
    zero      = rb();
    overflow  = rb();
    e.c   = fetch_ctl(1'b0);
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] inst, input int fw, input int mw,
                           input logic z, input logic o, input string tag);
    Inst_in = inst;
    build(inst, fw, mw, z, o, tag);
    run_plan(-1);
    if (plan_errs) do_reset({tag, "/reset"});
  endtask

  // Start an access, then assert reset while it is still waiting.
  task automatic abort_instr(input logic [31:0] inst, input int steps, input string tag);
    Inst_in = inst;
    build(inst, 2, 3, 1'b0, 1'b0, tag);
    run_plan(steps);
    do_reset({tag, "/abort"});
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [5:0]  ops[16] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                             6'h03, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h3f, 6'h10};
    logic [5:0]  fns[11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                             6'h02, 6'h08, 6'h3f, 6'h21};
    r = $urandom();
    r[31:26] = ops[$urandom_range(0, 15)];
    if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 10)];
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset("reset");

    // Directed cases
    run_instr(32'h0800_0040, 3, 0, 1'b0, 1'b0, "fetch_wait3");
    run_instr(32'h8C22_0004, 0, 2, 1'b0, 1'b0, "lw_wait2");
    run_instr(32'h0043_0820, 0, 0, 1'b0, 1'b1, "add_ovf_trap");
    run_instr(32'h1422_0003, 1, 0, 1'b1, 1'b0, "bne_z1");
    run_instr(32'h1422_0003, 0, 0, 1'b0, 1'b0, "bne_z0");
    run_instr(32'h1022_0003, 0, 0, 1'b1, 1'b0, "beq_z1");
    run_instr(32'h0C00_0010, 0, 0, 1'b0, 1'b0, "jal");
    run_instr(32'h03E0_0008, 0, 0, 1'b0, 1'b0, "jr");
    run_instr(32'h3442_00FF, 0, 0, 1'b0, 1'b1, "ori");
    run_instr(32'h2042_7FFF, 0, 0, 1'b0, 1'b1, "addi_ovf_trap");
    run_instr(32'h0043_0824, 0, 0, 1'b0, 1'b1, "and_ovf_ignored");
    run_instr(32'hAC22_0008, 2, 3, 1'b0, 1'b0, "sw_wait3");
    run_instr(32'hFC00_0000, 0, 0, 1'b0, 1'b0, "undef_op");

    // Reset during a fetch wait, a load wait and a store wait
    abort_instr(32'h0800_0000, 2, "if_wait");
    abort_instr(32'h8C22_0004, 6, "mem_rd_wait");
    abort_instr(32'hAC22_0004, 7, "mem_w_wait");

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      run_instr(rand_inst(), $urandom_range(0, 3), $urandom_range(0, 3),
                rb(), ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
